// File: rtl/attractor_finder.sv
// attractor_finder: steps a Boolean network from a seed until a state repeats.
// Reports transient length, attractor period and entry state. Rev 1.0
`default_nettype none

module attractor_finder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [0:WIDTH-1] seed,
  input  logic [0:WIDTH-1] next_status,
  output logic [0:WIDTH-1] status,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             is_fixed,
  output logic             is_cycle,
  output logic [CNT_W-1:0] transient_len,
  output logic [CNT_W-1:0] cycle_len,
  output logic [0:WIDTH-1] entry_state
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STEP   = 2'd1;
  localparam logic [1:0] SEARCH = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]       fsm;
  logic [CNT_W-1:0] count;
  logic [0:WIDTH-1] nxt;
  logic [0:WIDTH-1] hist [DEPTH];
  logic [DEPTH-1:0] match;
  logic             hit;
  logic [CNT_W-1:0] hit_idx;
  logic             full;

  // Only entries already written in this run take part in the compare.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign match[i] = (CNT_W'(i) < count) && (hist[i] == nxt);
  end

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = CNT_W'(i);
      end
    end
  end

  assign full     = (count == CNT_W'(DEPTH));
  assign busy     = (fsm != IDLE);
  assign done     = (fsm == DONE);
  assign is_fixed = found && (cycle_len == CNT_W'(1));
  assign is_cycle = found && (cycle_len > CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm           <= IDLE;
      count         <= '0;
      status        <= '0;
      nxt           <= '0;
      found         <= 1'b0;
      transient_len <= '0;
      cycle_len     <= '0;
      entry_state   <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (start) begin
            status        <= seed;
            count         <= CNT_W'(1);
            found         <= 1'b0;
            transient_len <= '0;
            cycle_len     <= '0;
            entry_state   <= '0;
            fsm           <= STEP;
          end
        end
        STEP: begin
          nxt <= next_status;
          fsm <= SEARCH;
        end
        SEARCH: begin
          if (hit) begin
            found         <= 1'b1;
            transient_len <= hit_idx;
            cycle_len     <= count - hit_idx;
            entry_state   <= hist[hit_idx[IDX_W-1:0]];
            fsm           <= DONE;
          end else if (full) begin
            found         <= 1'b0;
            transient_len <= '0;
            cycle_len     <= '0;
            entry_state   <= '0;
            fsm           <= DONE;
          end else begin
            status <= nxt;
            count  <= count + CNT_W'(1);
            fsm    <= STEP;
          end
        end
        DONE:    fsm <= IDLE;
        default: fsm <= IDLE;
      endcase
    end
  end

  // History needs no reset: stale entries are masked by count.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (fsm == IDLE && start) begin
        hist[0] <= seed;
      end else if (fsm == SEARCH && !hit && !full) begin
        hist[count[IDX_W-1:0]] <= nxt;
      end
    end
  end

endmodule

`default_nettype wire
